// File: rtl/shift_multiplier.sv
// Sequential shift-and-add unsigned multiplier.
// One multiplier bit is retired per enabled clock; result lands in a held register.
module shift_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;

    // Partial product for this step; also the final result on the last step.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end
        w_last = (r_count == CW'(WIDTH - 1));
    end

    // Control FSM and datapath; en low freezes everything, stretching done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else if (en) begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        r_product <= w_acc_next;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_shift_multiplier.sv
// Bench for shift_multiplier: vector table, directed corner sequences,
// and a start-held random sweep checked through an expected-result queue.
module tb_shift_multiplier;

    localparam int W = 16;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            start;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [2*W-1:0] exp_q[$];
    logic           prev_done = 1'b0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vt[7];

    shift_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Scoreboard side: one pop per done pulse, and the busy/done exclusion.
    always @(posedge clk) begin
        #1;
        chk("busy_done_excl", {63'd0, busy & done}, 64'd0);
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                chk("sb_product", {32'd0, product}, {32'd0, exp_q.pop_front()});
            end
        end
        prev_done = done;
    end

    task automatic wait_done(output int c, output int bc);
        c  = 0;
        bc = 0;
        while (!done && c < 60) begin
            if (busy) bc++;
            tick();
            c++;
        end
    endtask

    task automatic run_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [2*W-1:0] vp);
        int c;
        int bc;
        a     = va;
        b     = vb;
        en    = 1'b1;
        start = 1'b1;
        exp_q.push_back(vp);
        tick();
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        chk("accept_busy", {63'd0, busy}, 64'd1);
        wait_done(c, bc);
        chk("latency", 64'(c), 64'(W));
        chk("busy_cycles", 64'(bc), 64'(W));
        chk("product", {32'd0, product}, {32'd0, vp});
        tick();
        chk("done_single", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int c;
        int bc;
        int prev_acc;
        int guard;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vt[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vt[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vt[2] = '{16'h0000, 16'hABCD, 32'h00000000};
        vt[3] = '{16'h0001, 16'h0001, 32'h00000001};
        vt[4] = '{16'h8000, 16'h0002, 32'h00010000};
        vt[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vt[6] = '{16'h00FF, 16'h0100, 32'h0000FF00};

        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", {32'd0, product}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i].a, vt[i].b, vt[i].p);
        end

        // start re-pulsed mid-operation with new operands is ignored
        a = 16'd3;
        b = 16'd5;
        start = 1'b1;
        exp_q.push_back(32'h0000000F);
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        a = 16'd7;
        b = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(c, bc);
        chk("repulse_lat", 64'(c), 64'(W - 6));
        chk("repulse_product", {32'd0, product}, 64'h0F);
        for (int k = 0; k < 25; k++) tick();
        chk("repulse_q_empty", 64'(exp_q.size()), 64'd0);
        chk("repulse_idle", {63'd0, busy}, 64'd0);

        // four stalled cycles mid-BUSY delay done by exactly four
        a = 16'h1234;
        b = 16'h0010;
        start = 1'b1;
        exp_q.push_back(32'h00012340);
        tick();
        start = 1'b0;
        c  = 0;
        bc = 0;
        while (!done && c < 60) begin
            en = (c >= 6 && c < 10) ? 1'b0 : 1'b1;
            if (busy) bc++;
            tick();
            c++;
        end
        en = 1'b1;
        chk("stall_lat", 64'(c), 64'(W + 4));
        chk("stall_busy", 64'(bc), 64'(W + 4));
        chk("stall_product", {32'd0, product}, 64'h00012340);
        tick();

        // done pulse stretched while en is low
        a = 16'd5;
        b = 16'd6;
        start = 1'b1;
        exp_q.push_back(32'd30);
        tick();
        start = 1'b0;
        wait_done(c, bc);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stretch_done", {63'd0, done}, 64'd1);
        end
        en = 1'b1;
        tick();
        chk("stretch_end", {63'd0, done}, 64'd0);
        chk("stretch_product", {32'd0, product}, 64'd30);
        tick();

        // asynchronous reset mid-BUSY aborts with no done pulse
        a = 16'hFFFF;
        b = 16'h0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_product", {32'd0, product}, 64'd0);
        tick();
        rst_n = 1'b1;
        run_vec(16'd2, 16'd2, 32'd4);

        // random sweep with start held; accept period must be WIDTH+2
        a = 16'($urandom);
        b = 16'($urandom);
        exp_q.push_back(32'(a) * 32'(b));
        start = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 1000; k++) begin
            guard = 0;
            while (busy && guard < 60) begin
                tick();
                guard++;
            end
            while (!busy && guard < 60) begin
                tick();
                guard++;
            end
            if (guard >= 60) begin
                chk("sweep_timeout", 64'd1, 64'd0);
                break;
            end
            if (k > 0) chk("sweep_period", 64'(cyc - prev_acc), 64'(W + 2));
            prev_acc = cyc;
            if (k < 999) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (k == 10) begin
                    ra = 16'hFFFF;
                    rb = 16'hFFFF;
                end
                a = ra;
                b = rb;
                exp_q.push_back(32'(ra) * 32'(rb));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            tick();
            guard++;
        end
        chk("sweep_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
